// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and constants for l2_req_arbiter
package l2_arb_pkg;

   localparam int ARB_CNT_W       = 32;
   localparam int ARB_DEF_NUM_REQ = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } arb_state_t;

   // Index width for a requester count; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ARB_DEF_IDX_W = idx_w(ARB_DEF_NUM_REQ);

   typedef logic [ARB_DEF_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/l2_rr_picker.sv
// rtl/l2_rr_picker.sv - round-robin pick: first set request at or after rr_ptr, wrapping
module l2_rr_picker
   import l2_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = idx_w(NUM_REQ)
)
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   winner
);

   int idx;

   // Walk offsets from farthest to nearest so the nearest set request wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         idx = (int'(rr_ptr) + off) % NUM_REQ;
         if (req[idx[IDX_W-1:0]]) begin
            valid  = 1'b1;
            winner = idx[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/l2_req_arbiter.sv
// rtl/l2_req_arbiter.sv - round-robin N-requester front end onto the L2 proc-side bus
// Optional per-requester grant and conflict counters under `L2_ARB_STATS_EN.
module l2_req_arbiter
   import l2_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
)
(
   input  logic                               CLK,
   input  logic                               nRST,
   input  logic [NUM_REQ-1:0]                 m_ren,
   input  logic [NUM_REQ-1:0]                 m_wen,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]      m_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]      m_wdata,
   input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  m_byte_en,
   output logic [NUM_REQ*DATA_WIDTH-1:0]      m_rdata,
   output logic [NUM_REQ-1:0]                 m_busy,
   output logic                               s_ren,
   output logic                               s_wen,
   output logic [ADDR_WIDTH-1:0]              s_addr,
   output logic [DATA_WIDTH-1:0]              s_wdata,
   output logic [DATA_WIDTH/8-1:0]            s_byte_en,
   input  logic [DATA_WIDTH-1:0]              s_rdata,
   input  logic                               s_busy
`ifdef L2_ARB_STATS_EN
   ,
   output logic [NUM_REQ*ARB_CNT_W-1:0]       grant_cnt,
   output logic [ARB_CNT_W-1:0]               conflict_cnt
`endif
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = idx_w(NUM_REQ);

   arb_state_t              state, state_nxt;
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        win_idx;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_valid;
   logic [NUM_REQ-1:0]      req;
   logic                    done;
   logic                    win_live;
   logic                    deliver;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic [BE_W-1:0]         sel_be;
   logic                    sel_ren;
   logic                    sel_wen;
   logic [DATA_WIDTH-1:0]   rdata_q [NUM_REQ];

   assign req = m_ren | m_wen;

   l2_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .valid   (pick_valid),
      .winner  (pick_idx)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      sel_ren   = 1'b0;
      sel_wen   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            sel_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_be    = m_byte_en[i*BE_W +: BE_W];
            sel_ren   = m_ren[i];
            sel_wen   = m_wen[i];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = ISSUE;
         ISSUE:   if (!s_busy)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign done = (state == ISSUE) && !s_busy;

   // A winner that let go of its request still finishes downstream but gets no response.
   always_comb begin
      win_live = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_W'(i)) win_live = req[i];
      end
   end

   assign deliver = done && win_live && nRST;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         win_idx   <= '0;
         s_ren     <= 1'b0;
         s_wen     <= 1'b0;
         s_addr    <= '0;
         s_wdata   <= '0;
         s_byte_en <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && pick_valid) begin
            win_idx   <= pick_idx;
            s_addr    <= sel_addr;
            s_wdata   <= sel_wdata;
            s_byte_en <= sel_be;
            s_wen     <= sel_wen;
            s_ren     <= sel_ren & ~sel_wen;
         end
         if (done) begin
            s_ren  <= 1'b0;
            s_wen  <= 1'b0;
            rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (deliver && win_idx == IDX_W'(i)) rdata_q[i] <= s_rdata;
         end
      end
   end

   // The winner sees L2 data and its done pulse in the same cycle L2 drops busy.
   always_comb begin
      m_busy  = '1;
      m_rdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdata_q[i];
         if (deliver && win_idx == IDX_W'(i)) begin
            m_busy[i]                           = 1'b0;
            m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
         end
      end
   end

`ifdef L2_ARB_STATS_EN
   logic [ARB_CNT_W-1:0] grant_q [NUM_REQ];
   logic [ARB_CNT_W-1:0] conflict_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         conflict_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) grant_q[i] <= '0;
      end else begin
         if (state == IDLE && $countones(req) >= 2) conflict_q <= conflict_q + 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (done && win_idx == IDX_W'(i)) grant_q[i] <= grant_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*ARB_CNT_W +: ARB_CNT_W] = grant_q[i];
   end

   assign conflict_cnt = conflict_q;
`endif

endmodule
